// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Holds the per-channel FSM state encoding and the 50 MHz default cycle counts.
// It also provides a small helper used to size the channel counters.
package key_pkg;

  localparam int NUM_KEYS = 2;

  // 20 ms debounce, 0.5 s hold before first repeat, 0.1 s repeat period @ 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 25_000_000;
  localparam int DEF_REPEAT_CYCLES   = 5_000_000;

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_DOWN_CHK = 2'd1,
    ST_DOWN     = 2'd2,
    ST_UP_CHK   = 2'd3
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of raw pushbutton inputs and conditioned outputs.
//   key         raw buttons, active-low, asynchronous
//   key_down    debounced level, 1 = pressed
//   key_press   one-cycle strobe on accepted press
//   key_release one-cycle strobe on accepted release
//   key_repeat  one-cycle auto-repeat strobe while held
// master: board/stimulus side, slave: conditioner side.
interface key_conditioner_if;
  import key_pkg::*;

  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key,
    input  key_down,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key,
    output key_down,
    output key_press,
    output key_release,
    output key_repeat
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, debounce FSM and hold/repeat
// counter. All outputs are registered.
//   CLOCK_50    system clock
//   reset       asynchronous, active-high
//   key_n       raw button, active-low
//   key_down    debounced level
//   key_press   strobe on accepted press
//   key_release strobe on accepted release
//   key_repeat  auto-repeat strobe while held
//
// state    | meaning
// ---------+------------------------------------------------
// UP       | released, key_down = 0
// DOWN_CHK | candidate press, counting stable pressed cycles
// DOWN     | pressed, key_down = 1, hold counter running
// UP_CHK   | candidate release, key_down still 1, hold counter running
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic key_down,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int MAX_CYCLES = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  key_state_t    state;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  logic          first_rpt;   // 1 until the first repeat of the current hold
  logic [CW-1:0] hold_tc;
  logic          hold_hit;

  assign hold_tc  = first_rpt ? HOLD_TC : REP_TC;
  assign hold_hit = (hold_cnt == hold_tc);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_meta   <= 1'b0;
      sync        <= 1'b0;
      state       <= ST_UP;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      first_rpt   <= 1'b1;
      key_down    <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync_meta   <= ~key_n;
      sync        <= sync_meta;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;

      case (state)
        ST_UP: begin
          hold_cnt <= '0;
          if (sync) begin
            state   <= ST_DOWN_CHK;
            deb_cnt <= '0;
          end
        end

        ST_DOWN_CHK: begin
          if (!sync) begin
            state   <= ST_UP;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_TC) begin
            state     <= ST_DOWN;
            key_down  <= 1'b1;
            key_press <= 1'b1;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            first_rpt <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        ST_DOWN: begin
          if (!sync) begin
            state   <= ST_UP_CHK;
            deb_cnt <= '0;
          end
          if (hold_hit) begin
            key_repeat <= 1'b1;
            hold_cnt   <= '0;
            first_rpt  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_UP_CHK: begin
          if (!sync && deb_cnt == DEB_TC) begin
            // release wins: no repeat in this cycle
            state       <= ST_UP;
            key_down    <= 1'b0;
            key_release <= 1'b1;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
          end else begin
            if (sync) begin
              state   <= ST_DOWN;
              deb_cnt <= '0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
            // hold timing keeps running through a release bounce
            if (hold_hit) begin
              key_repeat <= 1'b1;
              hold_cnt   <= '0;
              first_rpt  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_UP;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronises and debounces each active-low key and
// produces a clean level plus press, release and auto-repeat strobes usable as
// clock enables by downstream CLOCK_50 logic.
//   CLOCK_50  system clock
//   reset     asynchronous, active-high
//   bus       key_conditioner_if slave: raw keys in, conditioned outputs out
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  key_conditioner_if.slave bus
);

  logic [NUM_KEYS-1:0] down_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;
  logic [NUM_KEYS-1:0] repeat_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .key_n       (bus.key[i]),
      .key_down    (down_w[i]),
      .key_press   (press_w[i]),
      .key_release (release_w[i]),
      .key_repeat  (repeat_w[i])
    );
  end

  assign bus.key_down    = down_w;
  assign bus.key_press   = press_w;
  assign bus.key_release = release_w;
  assign bus.key_repeat  = repeat_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, HOLD=10, REPEAT=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// After a key change at a falling edge, the next rising edge is the first
// sample, and the strobe appears in the cycle sampled 7 falling edges later.
module tb_key_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  key_conditioner_if bus();

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] seen;
    bus.key = 2'b11;

    // reset state
    cyc(2);
    check("rst_down", bus.key_down, 2'b00);
    check("rst_press", bus.key_press, 2'b00);
    check("rst_release", bus.key_release, 2'b00);
    check("rst_repeat", bus.key_repeat, 2'b00);
    rst = 1'b0;
    cyc(3);
    check("idle_down", bus.key_down, 2'b00);

    // clean press: strobe in cycle of edge E6 (t=0)
    bus.key = 2'b10;
    cyc(6);
    check("press_early", bus.key_press, 2'b00);
    check("down_early", bus.key_down, 2'b00);
    cyc(1);
    check("press_t0", bus.key_press, 2'b01);
    check("down_t0", bus.key_down, 2'b01);
    cyc(1);
    check("press_t1", bus.key_press, 2'b00);
    check("down_t1", bus.key_down, 2'b01);

    // hold/repeat at +10, +13, +16
    cyc(8);
    check("rpt_t9", bus.key_repeat, 2'b00);
    cyc(1);
    check("rpt_t10", bus.key_repeat, 2'b01);
    cyc(1);
    check("rpt_t11", bus.key_repeat, 2'b00);
    cyc(2);
    check("rpt_t13", bus.key_repeat, 2'b01);
    cyc(3);
    check("rpt_t16", bus.key_repeat, 2'b01);

    // release bounce: high for 2 samples, then low again
    bus.key = 2'b11;
    cyc(2);
    bus.key = 2'b10;
    check("rb_down_t18", bus.key_down, 2'b01);
    cyc(1);
    check("rb_rpt_t19", bus.key_repeat, 2'b01);
    check("rb_rel_t19", bus.key_release, 2'b00);
    cyc(1);
    check("rb_down_t20", bus.key_down, 2'b01);
    check("rb_rel_t20", bus.key_release, 2'b00);
    cyc(2);
    check("rb_rpt_t22", bus.key_repeat, 2'b01);
    cyc(1);
    check("rb_rel_t23", bus.key_release, 2'b00);
    check("rb_down_t23", bus.key_down, 2'b01);

    // clean release at t30
    bus.key = 2'b11;
    cyc(6);
    check("rel_early", bus.key_release, 2'b00);
    check("rel_down_early", bus.key_down, 2'b01);
    cyc(1);
    check("rel_t30", bus.key_release, 2'b01);
    check("rel_down_t30", bus.key_down, 2'b00);
    check("rel_rpt_t30", bus.key_repeat, 2'b00);
    seen = 2'b00;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      seen = seen | bus.key_repeat | bus.key_release | bus.key_press;
    end
    check("quiet_after_rel", seen, 2'b00);

    // bounce: low 3, high 1, low 3 -> nothing
    bus.key = 2'b10;
    cyc(3);
    bus.key = 2'b11;
    cyc(1);
    bus.key = 2'b10;
    cyc(3);
    bus.key = 2'b11;
    seen = 2'b00;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      seen = seen | bus.key_press | bus.key_down;
    end
    check("bounce_none", seen, 2'b00);

    // long hold afterwards -> one press
    bus.key = 2'b10;
    cyc(7);
    check("press2", bus.key_press, 2'b01);
    cyc(2);
    check("down2", bus.key_down, 2'b01);

    // reset mid-hold clears outputs immediately
    rst = 1'b1;
    #1;
    check("rst_mid_down", bus.key_down, 2'b00);
    check("rst_mid_press", bus.key_press, 2'b00);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    check("rst_press_early", bus.key_press, 2'b00);
    cyc(1);
    check("rst_press", bus.key_press, 2'b01);
    check("rst_press_down", bus.key_down, 2'b01);

    // independence: release key0, press both, release key1 only
    bus.key = 2'b11;
    cyc(7);
    check("ind_rel0", bus.key_release, 2'b01);
    cyc(3);
    bus.key = 2'b00;
    cyc(7);
    check("ind_press_both", bus.key_press, 2'b11);
    check("ind_down_both", bus.key_down, 2'b11);
    cyc(2);
    bus.key = 2'b10;
    cyc(6);
    check("ind_rel1_early", bus.key_release, 2'b00);
    cyc(1);
    check("ind_rel1", bus.key_release, 2'b10);
    check("ind_down_01", bus.key_down, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
